// File: rtl/myip_regs_pkg.sv
// Shared definitions for the myip AXI4-Lite register slave.
//   - Word offsets of the read/write registers and the ID word.
//   - Default ID word value and the OKAY response code.
//   - strb_merge: byte-enable merge of new write data into a register value.
package myip_regs_pkg;

    localparam logic [4:0]  REG0    = 5'd0;
    localparam logic [4:0]  REG1    = 5'd1;
    localparam logic [4:0]  REG2    = 5'd2;
    localparam logic [4:0]  REG3    = 5'd3;
    localparam logic [4:0]  ID_WORD = 5'd31;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hDECADE90;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

    // Replace each byte of cur whose strobe bit is set with the matching byte of wdat.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] cur,
        input logic [31:0] wdat,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/myip_axil_slave_regs.sv
// AXI4-Lite slave register file.
//   NUM_RW_REGS read/write 32-bit registers at word offsets 0 upward, a
//   read-only ID word at ID_OFFSET, every other word of the 32-word window
//   reads as zero. All responses are OKAY.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*            : read address and data channels
//   reg_out      : register k on bits [32k+31:32k]
//   reg_wr_pulse : one-cycle pulse on the cycle register k takes a new value
module myip_axil_slave_regs
    import myip_regs_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 7,
    parameter int          NUM_RW_REGS        = 4,
    parameter logic [6:0]  ID_OFFSET          = {ID_WORD, 2'b00},
    parameter logic [31:0] ID_VALUE           = ID_VALUE_DEFAULT
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_RW_REGS*32-1:0]         reg_out,
    output logic [NUM_RW_REGS-1:0]            reg_wr_pulse
);

    localparam logic [4:0] ID_IDX    = ID_OFFSET[6:2];
    localparam logic [5:0] NUM_REGS6 = 6'(NUM_RW_REGS);

    logic                   aw_full;
    logic                   w_full;
    logic                   bvalid;
    logic                   rvalid;
    logic [4:0]             aw_idx;
    logic [31:0]            w_data;
    logic [3:0]             w_strb;
    logic [31:0]            rdata;
    logic [31:0]            regs [NUM_RW_REGS];
    logic [NUM_RW_REGS-1:0] wr_pulse;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   commit;
    logic [4:0]             ar_idx;
    logic [31:0]            rd_mux;
    logic                   unused_ok;

    // Protection bits and the byte-offset/upper address bits carry no meaning here.
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = !aw_full && !bvalid;
    assign S_AXI_WREADY  = !w_full && !bvalid;
    assign S_AXI_ARREADY = !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign reg_wr_pulse  = wr_pulse;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    // Commit only once both halves are registered, giving a one-edge gap
    // between the last AW/W handshake and the register update.
    assign commit = aw_full && w_full;
    assign ar_idx = S_AXI_ARADDR[6:2];

    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = regs[g];
    end

    // Read mux: R/W registers take priority should ID_OFFSET overlap them.
    always_comb begin
        rd_mux = '0;
        if (ar_idx == ID_IDX) rd_mux = ID_VALUE;
        if ({1'b0, ar_idx} < NUM_REGS6) begin
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                if (ar_idx == 5'(k)) rd_mux = regs[k];
            end
        end
    end

    // Write-channel control, register file and strobe pulses
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid   <= 1'b0;
            wr_pulse <= '0;
            for (int k = 0; k < NUM_RW_REGS; k++) regs[k] <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
            end else begin
                if (aw_hs) aw_full <= 1'b1;
                if (w_hs)  w_full  <= 1'b1;
                if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
            end
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                wr_pulse[k] <= commit && (aw_idx == 5'(k));
                if (commit && (aw_idx == 5'(k)))
                    regs[k] <= strb_merge(regs[k], w_data, w_strb);
            end
        end
    end

    // Captured write address/data need no reset: aw_full/w_full qualify them.
    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_idx <= S_AXI_AWADDR[6:2];
        if (w_hs) begin
            w_data <= S_AXI_WDATA[31:0];
            w_strb <= S_AXI_WSTRB[3:0];
        end
    end

    // Read channel: a same-edge commit is not visible, so the old value is returned.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myip_axil_slave_regs.sv
module tb_myip_axil_slave_regs;
    import myip_regs_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [6:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    myip_axil_slave_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a);
        logic [4:0] idx;
        idx = a[6:2];
        if (idx < 5'd4) return model[idx[1:0]];
        if (idx == ID_WORD) return 32'hDECADE90;
        return 32'h0;
    endfunction

    function automatic logic [3:0] model_write(input logic [6:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [4:0] idx;
        idx = a[6:2];
        if (idx >= 5'd4) return 4'b0000;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx[1:0]][8*b +: 8] = d[8*b +: 8];
        return 4'b0001 << idx[1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_ack();
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", {127'b0, bvalid}, 128'd0);
    endtask

    // Full write: AW and W together; returns with BVALID observed (ack=0) or acknowledged.
    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit ack);
        int n;
        logic aw_done, w_done, pulse_seen;
        logic [3:0] exp_pulse;
        exp_pulse = model_write(a, d, s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready) w_done = 1'b1;
            tick();
            n++;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        pulse_seen = 1'b1;
        chk("bvalid_rise", {127'b0, bvalid}, 128'd1);
        chk("bresp", {126'b0, bresp}, 128'd0);
        chk("wr_pulse", {124'b0, reg_wr_pulse}, {124'b0, exp_pulse});
        if (pulse_seen && ack) b_ack();
    endtask

    task automatic axi_read(input logic [6:0] a, input int hold);
        int n;
        logic [31:0] exp, held;
        exp_q.push_back(model_read(a));
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("rvalid_rise", {127'b0, rvalid}, 128'd1);
        held = rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("rvalid_hold", {127'b0, rvalid}, 128'd1);
            chk("rdata_stable", {96'b0, rdata}, {96'b0, held});
            chk("arready_low", {127'b0, arready}, 128'd0);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk($sformatf("rdata@%02h", a), {96'b0, rdata}, {96'b0, exp});
        chk("rresp", {126'b0, rresp}, 128'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_clear", {127'b0, rvalid}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) model[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {127'b0, awready}, 128'd1);
        chk("rst_wready", {127'b0, wready}, 128'd1);
        chk("rst_arready", {127'b0, arready}, 128'd1);
        chk("rst_bvalid", {127'b0, bvalid}, 128'd0);
        chk("rst_rvalid", {127'b0, rvalid}, 128'd0);
        chk("rst_reg_out", reg_out, 128'd0);
        chk("rst_pulse", {124'b0, reg_wr_pulse}, 128'd0);
        chk("rst_rdata", {96'b0, rdata}, 128'd0);
        rst_n = 1'b1;
        tick();

        // Basic writes, then full window readback
        axi_write(7'h00, 32'd1, 4'hF, 1'b1);
        axi_write(7'h04, 32'd2, 4'hF, 1'b1);
        axi_write(7'h08, 32'd3, 4'hF, 1'b1);
        axi_write(7'h0C, 32'd4, 4'hF, 1'b1);
        for (int w = 0; w < 32; w++) axi_read(7'(w * 4), 0);
        chk("reg_out_all", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});

        // AW three cycles ahead of W
        awaddr = 7'h04; awvalid = 1'b1;
        chk("early_awready", {127'b0, awready}, 128'd1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("early_no_bvalid", {127'b0, bvalid}, 128'd0);
            chk("early_reg1_old", {96'b0, reg_out[63:32]}, 128'd2);
            chk("early_awready_low", {127'b0, awready}, 128'd0);
            tick();
        end
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        chk("early_wready", {127'b0, wready}, 128'd1);
        tick();
        wvalid = 1'b0;
        chk("early_bvalid_n", {127'b0, bvalid}, 128'd0);
        tick();
        chk("early_bvalid_n1", {127'b0, bvalid}, 128'd1);
        chk("early_reg1_new", {96'b0, reg_out[63:32]}, 128'hA5A5A5A5);
        chk("early_pulse", {124'b0, reg_wr_pulse}, 128'b0010);
        tick();
        chk("early_pulse_gone", {124'b0, reg_wr_pulse}, 128'd0);
        model[1] = 32'hA5A5A5A5;
        b_ack();

        // Partial strobes
        axi_write(7'h08, 32'h11223344, 4'hF, 1'b1);
        axi_write(7'h08, 32'hFFFFFFFF, 4'b0101, 1'b1);
        chk("strb_model", {96'b0, model[2]}, 128'h11FF33FF);
        axi_read(7'h08, 0);

        // Response back-pressure on both channels
        axi_write(7'h00, 32'hCAFEF00D, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_bvalid", {127'b0, bvalid}, 128'd1);
            chk("bp_awready", {127'b0, awready}, 128'd0);
            chk("bp_wready", {127'b0, wready}, 128'd0);
        end
        b_ack();
        axi_read(7'h00, 10);

        // ID word and unmapped word are write-protected
        axi_write(7'h7C, 32'h12345678, 4'hF, 1'b1);
        axi_write(7'h40, 32'h12345678, 4'hF, 1'b1);
        chk("prot_reg_out", reg_out, {model[3], model[2], model[1], model[0]});
        axi_read(7'h7C, 0);
        axi_read(7'h40, 0);

        // Reset while a response is pending
        axi_write(7'h0C, 32'h0BADBEEF, 4'hF, 1'b0);
        chk("pre_rst_bvalid", {127'b0, bvalid}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", {127'b0, bvalid}, 128'd0);
        chk("mid_rst_reg_out", reg_out, 128'd0);
        for (int k = 0; k < 4; k++) model[k] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        axi_read(7'h0C, 0);
        axi_read(7'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/myip_axil_slave_regs.md
Name: myip_axil_slave_regs

Overview:
- AXI4-Lite slave register file that answers the AXI4-Lite master VIP in the myip block design.
- Holds NUM_RW_REGS read/write 32-bit registers at 0x00 upward and a constant ID word at ID_OFFSET. All other words in the 32-word window read as zero.
- Register contents and per-register write strobes go to fabric logic.
- Write and read channels are independent; every response is OKAY.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7, byte address width; covers a 32-word window; must be >= 7.
- NUM_RW_REGS, 4, number of R/W registers at word offsets 0..NUM_RW_REGS-1; range 1..31.
- ID_OFFSET, 7'h7C, byte offset of the read-only ID word.
- ID_VALUE, 32'hDECADE90, value returned at ID_OFFSET.

Ports:
- S_AXI_ACLK in 1: sole clock.
- S_AXI_ARESETN in 1: asynchronous, active-low reset.
- S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH: write address.
- S_AXI_AWPROT in 3: ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake.
- S_AXI_WDATA in 32: write data.
- S_AXI_WSTRB in 4: byte enables.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake.
- S_AXI_BRESP out 2: always 2'b00.
- S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response handshake.
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH: read address.
- S_AXI_ARPROT in 3: ignored.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address handshake.
- S_AXI_RDATA out 32: read data.
- S_AXI_RRESP out 2: always 2'b00.
- S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data handshake.
- reg_out out NUM_RW_REGS*32: register k occupies bits [32k+31:32k].
- reg_wr_pulse out NUM_RW_REGS: one-cycle pulse on the cycle register k is updated.

Behaviour:
- Reset (async assert, sync release) clears: all registers, reg_wr_pulse, BVALID, RVALID, RDATA, and the aw_full/w_full holding flags.
  - Outputs after reset: AWREADY=WREADY=ARREADY=1, BRESP=RRESP=0.
- Address decode: word index = ADDR[6:2]; ADDR[1:0] and bits above 6 are ignored.
- Write channel, AW/W capture:
  - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
  - An AW handshake latches the address and sets aw_full. A W handshake latches data/strobe and sets w_full.
  - AW and W may arrive in either order or in the same cycle.
- Write channel, commit:
  - On the first edge where aw_full && w_full are both already registered, the write commits and BVALID is set.
  - Commit also clears aw_full and w_full.
  - Bytes with WSTRB[b]=1 update the target register; reg_wr_pulse[k] is high for that one cycle only.
  - Writes to the ID word or unmapped words have no effect and produce no pulse, but still get an OKAY response.
- Write channel, response:
  - BVALID holds until BREADY; it clears on the edge where BVALID && BREADY.
  - No AW/W is accepted while BVALID=1.
  - Latency: AW+W handshake at edge N -> reg_out updated and BVALID=1 at edge N+1.
- Read channel:
  - ARREADY = !RVALID.
  - An AR handshake at edge N loads RDATA and sets RVALID at edge N.
  - RDATA value: R/W register value; ID_VALUE at ID_OFFSET; 0 for all other words.
  - RVALID and RDATA hold until RREADY; RVALID clears on the RVALID && RREADY edge, and the next AR can be accepted one cycle later.
- Same-edge collision: a read and a write commit to the same register on the same edge -> the read returns the old value.
- Reset mid-transaction drops any pending write or read; the master must also be in reset.
- No SLVERR/DECERR is ever generated; AxPROT has no effect.

Decomposition:
- Package myip_regs_pkg holds:
  - word-offset localparams (REG0..REG3, ID_WORD = 5'd31);
  - ID_VALUE default;
  - RESP_OKAY = 2'b00;
  - a function for the byte-strobe merge.
- No sub-module: write and read control are each small enough to live in this module.

Test Plan:
- Write 1,2,3,4 to 0x00,0x04,0x08,0x0C with full strobes, then read 0x00..0x7C -> 1,2,3,4, then zeros, and 0xDECADE90 at 0x7C; every BRESP/RRESP = 0.
- AW presented 3 cycles before W at 0x04 with data 0xA5A5A5A5 -> no write until W arrives; BVALID rises one cycle after the W handshake; reg_out[63:32]=0xA5A5A5A5 and reg_wr_pulse=4'b0010 for one cycle.
- WSTRB=4'b0101 write of 0xFFFFFFFF to 0x08 holding 0x11223344 -> readback 0x11FF33FF.
- BREADY held low 10 cycles -> BVALID stays 1 and AWREADY/WREADY stay 0 throughout; RREADY held low likewise -> RDATA stable and ARREADY=0.
- Write 0x12345678 to 0x7C and to 0x40 -> OKAY responses, no reg_wr_pulse, reads return 0xDECADE90 and 0.
- Assert S_AXI_ARESETN low while BVALID=1 after writing 0x0C -> BVALID drops immediately; reads after release return 0 at 0x0C.
